// File: rtl/riscv_core_dpath_regfile_mp_if.sv
// Operand-read / writeback bundle for the multi-ported integer register file.
// master: decode + writeback side; slave: the register file.
interface riscv_core_dpath_regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_WR-1:0]        wen_p;
  logic [NUM_WR*ADDR_W-1:0] waddr_p;
  logic [NUM_WR*DATA_W-1:0] wdata_p;
  logic                     init_done;
  logic                     wr_conflict;

  modport master (
    output raddr,
    output wen_p,
    output waddr_p,
    output wdata_p,
    input  rdata,
    input  init_done,
    input  wr_conflict
  );

  modport slave (
    input  raddr,
    input  wen_p,
    input  waddr_p,
    input  wdata_p,
    output rdata,
    output init_done,
    output wr_conflict
  );
endinterface

// File: rtl/riscv_core_dpath_regfile_mp.sv
// Multi-ported integer register file with x0 hard-wired to zero and a post-reset clear sweep.
// Optional write-to-read bypass enabled by defining RISCV_REGFILE_BYPASS_EN.
module riscv_core_dpath_regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  riscv_core_dpath_regfile_mp_if.slave   rf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;
  logic              wr_conflict_q, wr_conflict_d;

  // Entry 0 is never written; reads of x0 are forced to zero.
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_WR-1:0][ADDR_W-1:0] waddr;
  logic [NUM_WR-1:0][DATA_W-1:0] wdata;
  logic [NUM_WR-1:0]             wr_valid;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  always_comb begin
    raddr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      raddr[i] = rf.raddr[i*ADDR_W +: ADDR_W];
    end
  end

  // A write port is live only in RUN, when enabled, and when it does not target x0.
  always_comb begin
    waddr    = '0;
    wdata    = '0;
    wr_valid = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      waddr[j]    = rf.waddr_p[j*ADDR_W +: ADDR_W];
      wdata[j]    = rf.wdata_p[j*DATA_W +: DATA_W];
      wr_valid[j] = (state_q == StRun) && rf.wen_p[j] && (waddr[j] != '0);
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      for (int unsigned k = j + 1; k < NUM_WR; k++) begin
        if (wr_valid[j] && wr_valid[k] && (waddr[j] == waddr[k])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    if (state_q == StClear) begin
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StClear;
      clr_ptr_q     <= ADDR_W'(1);
      init_done_q   <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      init_done_q   <= init_done_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Ascending port order: the younger (higher-index) write lands last and wins.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == StClear) begin
        regs_q[clr_ptr_q] <= '0;
      end else begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_valid[j]) begin
            regs_q[waddr[j]] <= wdata[j];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if ((state_q == StRun) && (raddr[i] != '0)) begin
        rdata[i] = regs_q[raddr[i]];
`ifdef RISCV_REGFILE_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_valid[j] && (waddr[j] == raddr[i])) begin
            rdata[i] = wdata[j];
          end
        end
`endif
      end
    end
  end

  always_comb begin
    rf.rdata = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rf.rdata[i*DATA_W +: DATA_W] = rdata[i];
    end
  end

  assign rf.init_done   = init_done_q;
  assign rf.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_riscv_core_dpath_regfile_mp.sv
// Directed bench for riscv_core_dpath_regfile_mp: default 4R/2W build plus a 6R/4W, 64-bit instance.
module tb_riscv_core_dpath_regfile_mp;

  logic clk;
  logic reset_n;
  logic reset2_n;
  int   checks;
  int   failures;

  riscv_core_dpath_regfile_mp_if #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)
  ) bus ();

  riscv_core_dpath_regfile_mp_if #(
    .DATA_W(64), .ADDR_W(4), .NUM_RD(6), .NUM_WR(4)
  ) bus2 ();

  riscv_core_dpath_regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (bus.slave)
  );

  riscv_core_dpath_regfile_mp #(
    .DATA_W(64), .ADDR_W(4), .NUM_RD(6), .NUM_WR(4)
  ) u_dut2 (
    .clk     (clk),
    .reset_n (reset2_n),
    .rf      (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    bus.wen_p[p]            = 1'b1;
    bus.waddr_p[p*5 +: 5]   = a;
    bus.wdata_p[p*32 +: 32] = d;
  endtask

  task automatic wr_clr();
    bus.wen_p = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] e, input string tag);
    bus.raddr[p*5 +: 5] = a;
    #1;
    chk(tag, 64'(bus.rdata[p*32 +: 32]), 64'(e));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    reset2_n = 1'b0;
    bus.raddr    = '0;
    bus.wen_p    = '0;
    bus.waddr_p  = '0;
    bus.wdata_p  = '0;
    bus2.raddr   = '0;
    bus2.wen_p   = '0;
    bus2.waddr_p = '0;
    bus2.wdata_p = '0;

    // Reset held for two edges
    step();
    step();
    chk("rst_init_done", 64'(bus.init_done), 64'd0);
    chk("rst_wr_conflict", 64'(bus.wr_conflict), 64'd0);
    rd(0, 5'd3, 32'h0, "rst_read_x3");

    // Clear sweep: 31 edges; colliding write to x5 in CLEAR must be dropped
    reset_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      if (k == 20) begin
        wr(0, 5'd5, 32'hCAFE_0000);
        wr(1, 5'd5, 32'hBEEF_0000);
        rd(2, 5'd5, 32'h0, "clr_read_no_bypass");
      end
      step();
      wr_clr();
      if (k == 10) rd(1, 5'd31, 32'h0, "clr_read_x31");
      if (k == 20) chk("clr_no_conflict", 64'(bus.wr_conflict), 64'd0);
      if (k == 30) chk("clr_init_done_30", 64'(bus.init_done), 64'd0);
      if (k == 31) chk("clr_init_done_31", 64'(bus.init_done), 64'd1);
    end
    for (int a = 0; a < 32; a++) begin
      rd(a % 4, 5'(a), 32'h0, "sweep_zero");
    end

    // Basic dual write
    wr(0, 5'd3, 32'hDEAD_BEEF);
    wr(1, 5'd7, 32'h1234_5678);
    step();
    wr_clr();
    rd(0, 5'd3, 32'hDEAD_BEEF, "basic_p0_x3");
    rd(1, 5'd7, 32'h1234_5678, "basic_p1_x7");
    rd(2, 5'd0, 32'h0, "basic_p2_x0");
    rd(3, 5'd3, 32'hDEAD_BEEF, "basic_p3_x3");
    chk("basic_no_conflict", 64'(bus.wr_conflict), 64'd0);

    // Same-address collision: port1 wins, one-cycle flag
    wr(0, 5'd9, 32'h1111);
    wr(1, 5'd9, 32'h2222);
    step();
    wr_clr();
    chk("coll_flag", 64'(bus.wr_conflict), 64'd1);
    rd(0, 5'd9, 32'h2222, "coll_x9");
    step();
    chk("coll_flag_drop", 64'(bus.wr_conflict), 64'd0);

    // Both ports write x0: no effect, no conflict
    wr(0, 5'd0, 32'h5);
    wr(1, 5'd0, 32'h6);
    step();
    wr_clr();
    chk("x0_no_conflict", 64'(bus.wr_conflict), 64'd0);
    rd(1, 5'd0, 32'h0, "x0_zero");

    // Disabled port with matching address neither writes nor conflicts
    wr(0, 5'd12, 32'hAA);
    bus.waddr_p[5 +: 5]  = 5'd12;
    bus.wdata_p[32 +: 32] = 32'hBB;
    step();
    wr_clr();
    rd(2, 5'd12, 32'hAA, "wen_gate_x12");
    chk("wen_gate_no_conflict", 64'(bus.wr_conflict), 64'd0);

    // Bypass behaviour
    wr(0, 5'd4, 32'hA);
    step();
    wr_clr();
    wr(1, 5'd4, 32'hB);
`ifdef RISCV_REGFILE_BYPASS_EN
    rd(0, 5'd4, 32'hB, "bypass_same_cycle");
`else
    rd(0, 5'd4, 32'hA, "no_bypass_same_cycle");
`endif
    step();
    wr_clr();
    rd(0, 5'd4, 32'hB, "bypass_next_cycle");

    // Mid-operation reset
    wr(0, 5'd10, 32'h55);
    step();
    wr_clr();
    rd(3, 5'd10, 32'h55, "mid_pre_x10");
    reset_n = 1'b0;
    wr(0, 5'd11, 32'h77);
    step();
    wr_clr();
    reset_n = 1'b1;
    chk("mid_init_done_low", 64'(bus.init_done), 64'd0);
    rd(3, 5'd10, 32'h0, "mid_clear_read");
    for (int k = 1; k <= 30; k++) step();
    chk("mid_init_done_30", 64'(bus.init_done), 64'd0);
    step();
    chk("mid_init_done_31", 64'(bus.init_done), 64'd1);
    rd(3, 5'd10, 32'h0, "mid_x10_zero");
    rd(2, 5'd11, 32'h0, "mid_x11_zero");

    // Wide instance: 15-edge sweep, four-way collision
    reset2_n = 1'b1;
    for (int k = 1; k <= 14; k++) step();
    chk("p_init_done_14", 64'(bus2.init_done), 64'd0);
    step();
    chk("p_init_done_15", 64'(bus2.init_done), 64'd1);
    bus2.wen_p   = 4'hF;
    bus2.waddr_p = {4'd6, 4'd6, 4'd6, 4'd6};
    bus2.wdata_p = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002,
                    64'h1111_0000_0000_0001, 64'h0000_0000_0000_0000};
    step();
    bus2.wen_p = '0;
    bus2.raddr = {4'd6, 20'd0};
    #1;
    chk("p_four_way_data", bus2.rdata[5*64 +: 64], 64'h3333_0000_0000_0003);
    chk("p_four_way_conflict", 64'(bus2.wr_conflict), 64'd1);
    bus2.wen_p   = 4'hF;
    bus2.waddr_p = {4'd3, 4'd2, 4'd2, 4'd2};
    bus2.wdata_p = {64'hD3, 64'hC2, 64'hB1, 64'hA0};
    step();
    bus2.wen_p = '0;
    bus2.raddr = {4'd3, 4'd0, 4'd0, 4'd0, 4'd2, 4'd6};
    #1;
    chk("p_mix_x6", bus2.rdata[0 +: 64], 64'h3333_0000_0000_0003);
    chk("p_mix_x2", bus2.rdata[64 +: 64], 64'hC2);
    chk("p_mix_x3", bus2.rdata[5*64 +: 64], 64'hD3);
    chk("p_mix_conflict", 64'(bus2.wr_conflict), 64'd1);
    step();
    chk("p_conflict_drop", 64'(bus2.wr_conflict), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
